shift_iter: RTL



---
 rtl/shift_iter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_iter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_iter
//  Brief    : Multi-cycle iterative shifter (SLL / SRL / SRA, 32-bit word,
//             shift amount 0-31), one bit position per clock, returned
//             through a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:31] X,
  input  logic [0:4]  shamt,
  input  logic        arith,
  input  logic        right,
  output logic        busy,
  output logic        done,
  output logic [0:31] Z
);

  // Two-state controller: waiting for a request, or stepping the accumulator.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [0:31] r_acc;      // operand being shifted in place
  logic [0:4]  r_cnt;      // remaining single-bit steps
  logic        r_arith;    // mode captured at accept time
  logic        r_right;    // direction captured at accept time
  logic        r_done;
  logic [0:31] r_z;

  logic        w_accept;   // request taken this edge
  logic        w_finish;   // result published this edge
  logic        w_fill;     // bit shifted in at the MSB on a right shift
  logic [0:31] w_acc_step; // accumulator after one step

  // State register; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode. A request is only considered in IDLE,
  // so start during RUN (including the finishing edge) is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == 5'd0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // One-position shift. Bit 0 is the MSB; for arithmetic right shifts it
  // is the original sign bit and stays so, since it refills itself.
  always_comb begin
    w_fill     = r_right & r_arith & r_acc[0];
    w_acc_step = r_acc;
    if (r_right) begin
      w_acc_step = {w_fill, r_acc[0:30]};
    end else begin
      w_acc_step = {r_acc[1:31], 1'b0};
    end
  end

  // Datapath: load on accept, step while counting, publish on finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_arith <= 1'b0;
      r_right <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= '0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_acc   <= X;
        r_cnt   <= shamt;
        r_arith <= arith;
        r_right <= right;
      end else if ((r_state == ST_RUN) && !w_finish) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_finish) begin
        r_z <= r_acc;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign Z    = r_z;

endmodule
`default_nettype wire
